conv_pass_sequencer: RTL and testbench
======================================

# conv_pass_sequencer

Top-level scheduler for the separable Gaussian blur. It runs the row-convolution engine once or twice: pass 0 reads SRAM A and writes transposed into SRAM B, and pass 1 reads SRAM B and writes transposed back into A. It swaps image dimensions between passes and holds the engine in reset between runs. Between jobs it gives the host exclusive access to either SRAM.

## Interface
- SETTLE_CYCLES, 2: cycles eng_rstn is held low in ARM before each pass; legal range 1..15.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job request; sampled only in IDLE.
- abort  in  1  one-cycle job cancel; honoured in any non-IDLE state.
- cfg_nrows  in  8  source image rows; latched on accepted start.
- cfg_ncols  in  8  source image cols; latched on accepted start.
- cfg_sigma  in  3  kernel select; latched on accepted start.
- cfg_two_pass  in  1  1 = both axes (2 passes), 0 = pass 0 only; latched on accepted start.
- busy  out  1  job in progress (state != IDLE).
- done  out  1  one-cycle pulse when a job completes normally.
- cfg_err  out  1  sticky; set on a rejected start, cleared by the next accepted start.
- pass_idx  out  1  current pass.
- host_req  in  1  host wants SRAM access.
- host_sel_b  in  1  host target: 0 = A, 1 = B.
- host_ctrl  in  img_sram_ctrl_t  host SRAM command.
- host_gnt  out  1  host command is being forwarded this cycle.
- eng_rstn  out  1  engine run/reset (registered).
- eng_nrows  out  8  engine row count.
- eng_ncols  out  8  engine col count.
- eng_sigma  out  3  engine kernel select.
- eng_transpose  out  1  engine transpose-to-buffer select.
- eng_busy  in  1  engine busy.
- eng_img_ctrl  in  img_sram_ctrl_t  engine read-side SRAM command.
- eng_buf_ctrl  in  img_sram_ctrl_t  engine write-side SRAM command.
- eng_dout  out  8  read data to engine.
- sram_a_ctrl  out  img_sram_ctrl_t  command to SRAM A.
- sram_b_ctrl  out  img_sram_ctrl_t  command to SRAM B.
- sram_a_dout  in  8  read data from SRAM A.
- sram_b_dout  in  8  read data from SRAM B.

## Operation
- States: IDLE, ARM, RUN, DONE.
- Reset values: state IDLE, busy 0, done 0, cfg_err 0, pass_idx 0, eng_rstn 0, host_gnt 0, latched configuration 0.
- IDLE, start=1, cfg_ncols>=6 and cfg_nrows>=1:
  - latch cfg_*; clear cfg_err; pass_idx<=0; settle counter<=SETTLE_CYCLES; go to ARM.
- IDLE, start=1 with cfg_ncols<6 or cfg_nrows==0: set cfg_err and stay in IDLE.
- ARM:
  - eng_rstn=0; decrement the counter each cycle.
  - Counter reaching 0: clear the seen_busy flag; go to RUN.
- RUN:
  - eng_rstn=1.
  - eng_busy=1 sets seen_busy.
  - Pass ends when seen_busy=1 and eng_busy=0.
  - Pass end with pass_idx=0 and two_pass=1: pass_idx<=1; counter<=SETTLE_CYCLES; go to ARM.
  - Any other pass end: go to DONE.
- DONE: done=1 for exactly this cycle; eng_rstn=0; next state IDLE.
- abort in ARM or RUN: eng_rstn<=0 and go to IDLE with no done pulse. abort coincident with a pass end also wins.
- Engine configuration by pass:
  - Pass 0: eng_nrows=nrows, eng_ncols=ncols.
  - Pass 1: eng_nrows=ncols, eng_ncols=nrows (dimensions swapped).
  - eng_transpose=two_pass in pass 0 and 1 in pass 1.
  - eng_sigma=latched sigma.
- SRAM routing, combinational:
  - In ARM, RUN and DONE, pass 0: eng_img_ctrl→A, eng_buf_ctrl→B, eng_dout=sram_a_dout.
  - In ARM, RUN and DONE, pass 1: eng_img_ctrl→B, eng_buf_ctrl→A, eng_dout=sram_b_dout.
  - In IDLE: host_gnt=host_req. When granted, host_ctrl→selected SRAM.
  - Idle SRAM command value: all fields 0 (write_en=0, sense_en=0). Any SRAM not driven by the routing above receives this value.
  - host_gnt=0 outside IDLE; host commands are dropped, not queued.
- The host reads data directly from sram_a_dout and sram_b_dout.

## Timing
- Cycle 0: start accepted. Cycles 1..SETTLE_CYCLES: ARM. Cycle SETTLE_CYCLES+1: RUN, eng_rstn=1.
- eng_rstn is registered: it rises on the same edge that enters RUN and falls on the edge that leaves RUN.
- done asserts one cycle after the sampled final pass end. busy falls on the following edge.
- SRAM muxes have zero latency; read latency is the SRAM's one cycle.
- Async reset mid-job:
  - all outputs return to their reset values immediately;
  - the SRAM commands become the idle value, with write_en=0 the same cycle;
  - the job is lost and no done pulse is produced.
- If eng_busy never rises, the block stays in RUN until abort or reset (no watchdog).

## Test plan
- 8×8, two_pass=1, SETTLE_CYCLES=2, engine model:
  - Expect ARM for 2 cycles in each pass.
  - Expect pass 0 with eng_nrows=8, eng_ncols=8 and pass 1 the same.
  - Expect B written in pass 0, A written in pass 1, and one done pulse.
- 6×10 (nrows=6, ncols=10), two_pass=1:
  - Expect pass 0 with eng_nrows=6, eng_ncols=10, eng_transpose=1.
  - Expect pass 1 with eng_nrows=10, eng_ncols=6.
- two_pass=0: expect a single pass with eng_transpose=0, no pass_idx=1 phase, and done.
- start with ncols=5: expect cfg_err=1 and busy=0. A following start with valid dimensions clears cfg_err.
- Host access:
  - host_req held across a whole job: expect host_gnt=1 only in IDLE, and host_sel_b=1 writes reaching only SRAM B.
  - Expect no host write_en reaching either SRAM during RUN.
- abort in pass 1 RUN: expect eng_rstn=0 and IDLE next cycle, with no done pulse.
- rstn pulsed mid-pass 0: expect all outputs at reset values immediately and both SRAM write_en=0.

Source files
------------

// File: rtl/conv_pass_sequencer.sv
// Pass scheduler for the separable Gaussian blur: runs the row engine once or twice,
// swapping image dimensions and SRAM roles between passes, and lends the SRAMs to the host when idle.
package img_sram_pkg;
  typedef struct packed {
    logic        write_en;
    logic        sense_en;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } img_sram_ctrl_t;

  localparam img_sram_ctrl_t SRAM_CTRL_IDLE = '0;
endpackage

module conv_pass_sequencer
  import img_sram_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic [7:0]     cfg_nrows,
  input  logic [7:0]     cfg_ncols,
  input  logic [2:0]     cfg_sigma,
  input  logic           cfg_two_pass,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic           pass_idx,
  input  logic           host_req,
  input  logic           host_sel_b,
  input  img_sram_ctrl_t host_ctrl,
  output logic           host_gnt,
  output logic           eng_rstn,
  output logic [7:0]     eng_nrows,
  output logic [7:0]     eng_ncols,
  output logic [2:0]     eng_sigma,
  output logic           eng_transpose,
  input  logic           eng_busy,
  input  img_sram_ctrl_t eng_img_ctrl,
  input  img_sram_ctrl_t eng_buf_ctrl,
  output logic [7:0]     eng_dout,
  output img_sram_ctrl_t sram_a_ctrl,
  output img_sram_ctrl_t sram_b_ctrl,
  input  logic [7:0]     sram_a_dout,
  input  logic [7:0]     sram_b_dout
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_settle_cnt;
  logic       r_seen_busy;
  logic       r_pass_idx;
  logic       r_busy;
  logic       r_done;
  logic       r_cfg_err;
  logic       r_eng_rstn;
  logic [7:0] r_nrows;
  logic [7:0] r_ncols;
  logic [2:0] r_sigma;
  logic       r_two_pass;

  logic       w_cfg_ok;
  logic       w_pass_end;
  logic       w_more_passes;
  logic       w_host_gnt;

  // The engine needs at least 6 columns for its 5-tap window plus one output.
  assign w_cfg_ok      = (cfg_ncols >= 8'd6) && (cfg_nrows != 8'd0);
  assign w_pass_end    = r_seen_busy && !eng_busy;
  assign w_more_passes = !r_pass_idx && r_two_pass;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_seen_busy  <= 1'b0;
      r_pass_idx   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_eng_rstn   <= 1'b0;
      r_nrows      <= '0;
      r_ncols      <= '0;
      r_sigma      <= '0;
      r_two_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_nrows      <= cfg_nrows;
              r_ncols      <= cfg_ncols;
              r_sigma      <= cfg_sigma;
              r_two_pass   <= cfg_two_pass;
              r_cfg_err    <= 1'b0;
              r_pass_idx   <= 1'b0;
              r_settle_cnt <= SETTLE;
              r_busy       <= 1'b1;
              r_state      <= S_ARM;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (abort) begin
            r_eng_rstn <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
            if (r_settle_cnt <= 4'd1) begin
              r_seen_busy <= 1'b0;
              r_eng_rstn  <= 1'b1;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A pass only ends after the engine has been seen busy, so a slow start is not a finish.
          if (abort) begin
            r_eng_rstn <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_pass_end) begin
            r_eng_rstn <= 1'b0;
            if (w_more_passes) begin
              r_pass_idx   <= 1'b1;
              r_settle_cnt <= SETTLE;
              r_state      <= S_ARM;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (eng_busy) begin
            r_seen_busy <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_eng_rstn <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign pass_idx = r_pass_idx;
  assign eng_rstn = r_eng_rstn;

  // The second pass works on the transposed image, so rows and columns trade places.
  assign eng_nrows     = r_pass_idx ? r_ncols : r_nrows;
  assign eng_ncols     = r_pass_idx ? r_nrows : r_ncols;
  assign eng_sigma     = r_sigma;
  assign eng_transpose = r_pass_idx | r_two_pass;

  // Gating the host path with rstn keeps both SRAMs quiet while reset is asserted.
  always_comb begin
    sram_a_ctrl = SRAM_CTRL_IDLE;
    sram_b_ctrl = SRAM_CTRL_IDLE;
    eng_dout    = '0;
    w_host_gnt  = 1'b0;
    if (r_state == S_IDLE) begin
      if (host_req && rstn) begin
        w_host_gnt = 1'b1;
        if (host_sel_b) begin
          sram_b_ctrl = host_ctrl;
        end else begin
          sram_a_ctrl = host_ctrl;
        end
      end
    end else if (!r_pass_idx) begin
      sram_a_ctrl = eng_img_ctrl;
      sram_b_ctrl = eng_buf_ctrl;
      eng_dout    = sram_a_dout;
    end else begin
      sram_a_ctrl = eng_buf_ctrl;
      sram_b_ctrl = eng_img_ctrl;
      eng_dout    = sram_b_dout;
    end
  end

  assign host_gnt = w_host_gnt;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Randomised bench for conv_pass_sequencer: spec-level job model, engine model and host traffic generator.
module tb_conv_pass_sequencer;
  import img_sram_pkg::*;

  localparam int SETTLE = 2;

  logic           clk;
  logic           rstn;
  logic           start;
  logic           abort;
  logic [7:0]     cfg_nrows;
  logic [7:0]     cfg_ncols;
  logic [2:0]     cfg_sigma;
  logic           cfg_two_pass;
  logic           busy;
  logic           done;
  logic           cfg_err;
  logic           pass_idx;
  logic           host_req;
  logic           host_sel_b;
  img_sram_ctrl_t host_ctrl;
  logic           host_gnt;
  logic           eng_rstn;
  logic [7:0]     eng_nrows;
  logic [7:0]     eng_ncols;
  logic [2:0]     eng_sigma;
  logic           eng_transpose;
  logic           eng_busy;
  img_sram_ctrl_t eng_img_ctrl;
  img_sram_ctrl_t eng_buf_ctrl;
  logic [7:0]     eng_dout;
  img_sram_ctrl_t sram_a_ctrl;
  img_sram_ctrl_t sram_b_ctrl;
  logic [7:0]     sram_a_dout;
  logic [7:0]     sram_b_dout;

  int n_chk = 0;
  int n_fail = 0;
  int host_mode = 0;
  bit eng_stall = 0;
  int job_id = 0;

  conv_pass_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_nrows(cfg_nrows), .cfg_ncols(cfg_ncols), .cfg_sigma(cfg_sigma), .cfg_two_pass(cfg_two_pass),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pass_idx(pass_idx),
    .host_req(host_req), .host_sel_b(host_sel_b), .host_ctrl(host_ctrl), .host_gnt(host_gnt),
    .eng_rstn(eng_rstn), .eng_nrows(eng_nrows), .eng_ncols(eng_ncols), .eng_sigma(eng_sigma),
    .eng_transpose(eng_transpose), .eng_busy(eng_busy), .eng_img_ctrl(eng_img_ctrl),
    .eng_buf_ctrl(eng_buf_ctrl), .eng_dout(eng_dout), .sram_a_ctrl(sram_a_ctrl),
    .sram_b_ctrl(sram_b_ctrl), .sram_a_dout(sram_a_dout), .sram_b_dout(sram_b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- job model: phase, settle countdown, pass bookkeeping
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;
  int         m_ph;
  int         m_left;
  bit         m_seen;
  bit         m_pass;
  bit         m_err;
  bit         m_two;
  logic [7:0] m_rows;
  logic [7:0] m_cols;
  logic [2:0] m_sig;

  initial begin
    m_ph = M_IDLE; m_left = 0; m_seen = 0; m_pass = 0; m_err = 0; m_two = 0;
    m_rows = '0; m_cols = '0; m_sig = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_ph = M_IDLE; m_left = 0; m_seen = 0; m_pass = 0; m_err = 0; m_two = 0;
        m_rows = '0; m_cols = '0; m_sig = '0;
      end else begin
        case (m_ph)
          M_IDLE: if (start) begin
            if (cfg_ncols >= 6 && cfg_nrows >= 1) begin
              m_rows = cfg_nrows; m_cols = cfg_ncols; m_sig = cfg_sigma; m_two = cfg_two_pass;
              m_err = 0; m_pass = 0; m_left = SETTLE; m_ph = M_ARM;
            end else begin
              m_err = 1;
            end
          end
          M_ARM: if (abort) m_ph = M_IDLE;
                 else begin
                   m_left = m_left - 1;
                   if (m_left == 0) begin m_seen = 0; m_ph = M_RUN; end
                 end
          M_RUN: if (abort) m_ph = M_IDLE;
                 else if (m_seen && !eng_busy) begin
                   if (!m_pass && m_two) begin m_pass = 1; m_left = SETTLE; m_ph = M_ARM; end
                   else m_ph = M_DONE;
                 end else if (eng_busy) m_seen = 1;
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- every-cycle comparison against the model
  initial begin
    img_sram_ctrl_t ea, eb;
    bit             eg;
    forever begin
      @(negedge clk);
      ea = '0; eb = '0; eg = 0;
      if (m_ph == M_IDLE) begin
        if (rstn && host_req) begin
          eg = 1;
          if (host_sel_b) eb = host_ctrl; else ea = host_ctrl;
        end
      end else if (!m_pass) begin
        ea = eng_img_ctrl; eb = eng_buf_ctrl;
        chk("eng_dout", eng_dout, sram_a_dout);
      end else begin
        ea = eng_buf_ctrl; eb = eng_img_ctrl;
        chk("eng_dout", eng_dout, sram_b_dout);
      end
      chk("busy", busy, m_ph != M_IDLE);
      chk("done", done, m_ph == M_DONE);
      chk("cfg_err", cfg_err, m_err);
      chk("pass_idx", pass_idx, m_pass);
      chk("eng_rstn", eng_rstn, m_ph == M_RUN);
      chk("host_gnt", host_gnt, eg);
      chk("eng_nrows", eng_nrows, m_pass ? m_cols : m_rows);
      chk("eng_ncols", eng_ncols, m_pass ? m_rows : m_cols);
      chk("eng_sigma", eng_sigma, m_sig);
      chk("eng_transpose", eng_transpose, m_pass ? 1'b1 : m_two);
      chk("sram_a_ctrl", sram_a_ctrl, ea);
      chk("sram_b_ctrl", sram_b_ctrl, eb);
    end
  end

  // ---------------- per-job statistics for the hand-computed expectations
  int         arm_cnt[2], wa[2], wb[2];
  bit         seen_p[2], p_tr[2];
  logic [7:0] p_rows[2], p_cols[2];
  int         idle_wa, idle_wb, gnt_busy, host_run_wr, done_cnt;

  initial begin
    int mon_job;
    mon_job = -1;
    forever begin
      @(negedge clk);
      if (mon_job != job_id) begin
        mon_job = job_id;
        for (int i = 0; i < 2; i++) begin
          arm_cnt[i] = 0; wa[i] = 0; wb[i] = 0; seen_p[i] = 0; p_tr[i] = 0; p_rows[i] = '0; p_cols[i] = '0;
        end
        idle_wa = 0; idle_wb = 0; gnt_busy = 0; host_run_wr = 0; done_cnt = 0;
      end
      if (rstn) begin
        if (busy && !eng_rstn && !done) arm_cnt[pass_idx]++;
        if (eng_rstn) begin
          seen_p[pass_idx] = 1; p_rows[pass_idx] = eng_nrows; p_cols[pass_idx] = eng_ncols;
          p_tr[pass_idx] = eng_transpose;
          if (sram_a_ctrl.write_en) wa[pass_idx]++;
          if (sram_b_ctrl.write_en) wb[pass_idx]++;
          if ((sram_a_ctrl.write_en && sram_a_ctrl.wdata == 8'hA5) ||
              (sram_b_ctrl.write_en && sram_b_ctrl.wdata == 8'hA5)) host_run_wr++;
        end
        if (!busy && sram_a_ctrl.write_en) idle_wa++;
        if (!busy && sram_b_ctrl.write_en) idle_wb++;
        if (busy && host_gnt) gnt_busy++;
        if (done) done_cnt++;
      end
    end
  end

  // ---------------- row engine model: short delay, busy burst writing the buffer, then idle
  initial begin
    int          e_wait, e_len;
    bit          e_fin;
    logic [15:0] e_addr;
    eng_busy = 0; eng_img_ctrl = '0; eng_buf_ctrl = '0;
    e_wait = 1; e_len = 2; e_fin = 0; e_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!eng_rstn) begin
        eng_busy = 0; eng_img_ctrl = '0; eng_buf_ctrl = '0;
        e_wait = $urandom_range(1, 3); e_len = $urandom_range(2, 6); e_fin = 0; e_addr = '0;
      end else if (eng_stall || e_fin) begin
        eng_busy = 0; eng_img_ctrl = '0; eng_buf_ctrl = '0;
      end else if (e_wait > 0) begin
        e_wait--;
      end else if (e_len > 0) begin
        eng_busy = 1;
        eng_img_ctrl = '{write_en: 1'b0, sense_en: 1'b1, addr: e_addr, wdata: 8'h00};
        eng_buf_ctrl = '{write_en: 1'b1, sense_en: 1'b0, addr: e_addr, wdata: 8'h3C};
        e_addr++; e_len--;
      end else begin
        eng_busy = 0; eng_img_ctrl = '0; eng_buf_ctrl = '0; e_fin = 1;
      end
    end
  end

  // ---------------- host traffic and SRAM read data
  initial begin
    host_req = 0; host_sel_b = 0; host_ctrl = '0; sram_a_dout = '0; sram_b_dout = '0;
    forever begin
      @(posedge clk); #1;
      sram_a_dout = 8'($urandom); sram_b_dout = 8'($urandom);
      case (host_mode)
        0: begin host_req = 0; host_sel_b = 0; host_ctrl = '0; end
        1: begin
          host_req = 1'($urandom); host_sel_b = 1'($urandom);
          host_ctrl = '{write_en: 1'($urandom), sense_en: 1'($urandom), addr: 16'($urandom), wdata: 8'($urandom)};
        end
        default: begin
          host_req = 1; host_sel_b = 1;
          host_ctrl = '{write_en: 1'b1, sense_en: 1'b0, addr: 16'($urandom), wdata: 8'hA5};
        end
      endcase
    end
  end

  task automatic run_job(input logic [7:0] r, input logic [7:0] c, input logic [2:0] s, input logic t);
    int cyc;
    cfg_nrows = r; cfg_ncols = c; cfg_sigma = s; cfg_two_pass = t;
    start = 1; step(1); start = 0;
    cyc = 0;
    while (busy && cyc < 3000) begin step(1); cyc++; end
    chk("job_complete", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, abort_at;
    rstn = 0; start = 0; abort = 0;
    cfg_nrows = '0; cfg_ncols = '0; cfg_sigma = '0; cfg_two_pass = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_eng_rstn", eng_rstn, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_host_gnt", host_gnt, 0);
    @(posedge clk); #3 rstn = 1;
    step(2);

    // 8x8 two-pass job
    job_id++;
    run_job(8'd8, 8'd8, 3'd3, 1'b1);
    chk("j1_arm_p0", arm_cnt[0], 2);
    chk("j1_arm_p1", arm_cnt[1], 2);
    chk("j1_rows_p0", p_rows[0], 8);
    chk("j1_cols_p0", p_cols[0], 8);
    chk("j1_rows_p1", p_rows[1], 8);
    chk("j1_cols_p1", p_cols[1], 8);
    chk("j1_b_written_p0", wb[0] > 0, 1);
    chk("j1_a_untouched_p0", wa[0], 0);
    chk("j1_a_written_p1", wa[1] > 0, 1);
    chk("j1_b_untouched_p1", wb[1], 0);
    chk("j1_done_pulses", done_cnt, 1);

    // 6x10 two-pass job: dimensions swap in pass 1
    job_id++;
    run_job(8'd6, 8'd10, 3'd1, 1'b1);
    chk("j2_rows_p0", p_rows[0], 6);
    chk("j2_cols_p0", p_cols[0], 10);
    chk("j2_tr_p0", p_tr[0], 1);
    chk("j2_rows_p1", p_rows[1], 10);
    chk("j2_cols_p1", p_cols[1], 6);
    chk("j2_tr_p1", p_tr[1], 1);

    // single-pass job
    job_id++;
    run_job(8'd7, 8'd9, 3'd2, 1'b0);
    chk("j3_tr_p0", p_tr[0], 0);
    chk("j3_no_pass1", seen_p[1], 0);
    chk("j3_ran_pass0", seen_p[0], 1);
    chk("j3_done_pulses", done_cnt, 1);

    // rejected starts, then a valid start clears the error
    cfg_nrows = 8'd8; cfg_ncols = 8'd5; start = 1; step(1); start = 0;
    chk("j4_err_set", cfg_err, 1);
    chk("j4_not_busy", busy, 0);
    step(2);
    chk("j4_err_sticky", cfg_err, 1);
    cfg_nrows = 8'd0; cfg_ncols = 8'd8; start = 1; step(1); start = 0;
    chk("j4_zero_rows_busy", busy, 0);
    job_id++;
    run_job(8'd8, 8'd6, 3'd0, 1'b0);
    chk("j4_err_cleared", cfg_err, 0);

    // host holds a B write request across a whole job
    host_mode = 2;
    job_id++;
    step(4);
    run_job(8'd8, 8'd8, 3'd5, 1'b1);
    step(2);
    chk("j5_gnt_while_busy", gnt_busy, 0);
    chk("j5_idle_a_writes", idle_wa, 0);
    chk("j5_idle_b_writes", idle_wb > 0, 1);
    chk("j5_host_write_in_run", host_run_wr, 0);
    host_mode = 1;

    // abort during pass 1 RUN
    job_id++;
    cfg_nrows = 8'd8; cfg_ncols = 8'd8; cfg_two_pass = 1; start = 1; step(1); start = 0;
    cyc = 0;
    while (!(pass_idx && eng_rstn) && cyc < 500) begin step(1); cyc++; end
    chk("j6_reached_p1_run", pass_idx && eng_rstn, 1);
    abort = 1; step(1); abort = 0;
    chk("j6_eng_rstn_low", eng_rstn, 0);
    chk("j6_idle", busy, 0);
    step(6);
    chk("j6_no_done", done_cnt, 0);

    // engine that never goes busy: the pass holds until abort
    eng_stall = 1;
    start = 1; step(1); start = 0;
    step(40);
    chk("j7_stall_in_run", {busy, eng_rstn}, 2'b11);
    abort = 1; step(1); abort = 0;
    chk("j7_stall_aborted", busy, 0);
    eng_stall = 0;

    // asynchronous reset in the middle of pass 0 with the engine writing
    host_mode = 2;
    job_id++;
    cfg_nrows = 8'd8; cfg_ncols = 8'd8; cfg_sigma = 3'd6; cfg_two_pass = 1; start = 1; step(1); start = 0;
    cyc = 0;
    while (!(eng_busy && !pass_idx && eng_rstn) && cyc < 500) begin step(1); cyc++; end
    chk("j8_reached_p0_write", eng_busy && eng_rstn, 1);
    #2 rstn = 0;
    #1;
    chk("j8_busy", busy, 0);
    chk("j8_done", done, 0);
    chk("j8_pass_idx", pass_idx, 0);
    chk("j8_eng_rstn", eng_rstn, 0);
    chk("j8_host_gnt", host_gnt, 0);
    chk("j8_a_write_en", sram_a_ctrl.write_en, 0);
    chk("j8_b_write_en", sram_b_ctrl.write_en, 0);
    chk("j8_eng_dims", {eng_nrows, eng_ncols, eng_sigma, eng_transpose}, 20'h0);
    @(posedge clk); #3 rstn = 1;
    step(3);
    chk("j8_no_done", done_cnt, 0);
    host_mode = 1;

    // random jobs with stray starts, random aborts and random host traffic
    for (int j = 0; j < 30; j++) begin
      job_id++;
      cfg_nrows = 8'($urandom_range(0, 12));
      cfg_ncols = 8'($urandom_range(3, 14));
      cfg_sigma = 3'($urandom);
      cfg_two_pass = 1'($urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      start = 1; step(1); start = 0;
      for (int c = 0; c < 400; c++) begin
        if (!busy) break;
        abort = (c == abort_at);
        start = ($urandom_range(0, 15) == 0);
        step(1);
      end
      abort = 0; start = 0;
      step(1);
      chk("rand_job_end", busy, 0);
    end

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
